imm_seq_ctrl: RTL and testbench
===============================

Name: imm_seq_ctrl

Overview:
- Decode-stage sequencer that classifies each fetched 24-bit instruction by opcode.
- Drives ImmSrc to the combinational zero-extend unit, captures its ExtImm result, and registers it toward the ID/EX boundary.
- Owns the valid/ready handshake between fetch and decode.
- Assembles the two-beat "wide immediate" instruction. The extend unit cannot produce it (ImmSrc 2'b10 has no extend case), so the sequencer builds it from two consecutive beats.

Parameters:
- N, 24, instruction and immediate width
- OPW, 5, opcode width (Instr[N-1:N-OPW])

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch presents Instr
- in_ready  output  1  sequencer accepts Instr this cycle
- Instr  input  N  instruction word; opcode = Instr[23:19], field = Instr[18:0]
- stall  input  1  hazard-unit freeze
- flush  input  1  branch-taken kill
- ImmSrc  output  2  to extend unit, combinational from Instr and state
- ExtImm  input  N  from extend unit, same cycle
- out_valid  output  1  Imm/OpOut valid toward ID/EX
- out_ready  input  1  downstream accepts
- Imm  output  N  registered immediate
- OpOut  output  OPW  registered opcode

Behaviour:
- Reset (rst=0, async): state=S_IDLE, out_valid=0, Imm=0, OpOut=0, hi register=0. ImmSrc=2'b00 while rst=0.
- Accept condition: acc = in_valid & in_ready.
- in_ready = rst & ~stall & ~flush & (~out_valid | out_ready).
- Opcode classes, from opcode[4:2]:
  - 00x: R-type, ImmSrc=00, Imm=0
  - 01x: I11, ImmSrc=00
  - 10x: B19, ImmSrc=01
  - 110: S7, ImmSrc=11
  - 111: WIDE, ImmSrc=10
- S_IDLE, acc with non-WIDE opcode:
  - Next edge: Imm=ExtImm (0 for R-type), OpOut=opcode, out_valid=1.
  - Latency is 1 cycle.
- S_IDLE, acc with WIDE opcode:
  - hi<=Instr[11:0], OpOut<=opcode, state->S_WIDE.
  - out_valid does not rise; any prior output is consumed normally per handshake.
- S_WIDE:
  - ImmSrc=10 and ExtImm is ignored.
  - The next accepted beat is the low half, whatever its opcode bits.
  - Imm<={hi, Instr[11:0]}, out_valid=1, state->S_IDLE.
- Output handshake:
  - out_valid=1 & out_ready=1 with no new acc: out_valid->0 next edge.
  - acc alongside consumption: the new result replaces the old (back-to-back, full throughput).
- Backpressure: out_valid=1 & out_ready=0 holds Imm/OpOut/out_valid stable and forces in_ready=0.
- Stall: in_ready=0; state, hi and outputs hold. A downstream out_ready handshake may still clear out_valid.
- Flush (synchronous): next edge out_valid=0 and state=S_IDLE, discarding any pending hi. Flush overrides acc and stall in the same cycle.
- Async reset mid-S_WIDE returns to S_IDLE immediately, with no output.

Optional Feature:
- Macro: IMM_SEQ_PERF_EN.
- When defined:
  - Adds outputs perf_instr_cnt[15:0] and perf_wide_cnt[15:0].
  - perf_instr_cnt increments on every out_valid rising as a completed instruction (out_valid set at an edge).
  - perf_wide_cnt increments on each WIDE completion.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst.
  - Flush does not clear them.
- When undefined: the ports and logic are absent, with identical functional behaviour.

Decomposition:
- Package imm_seq_pkg holds:
  - imm_src_t enum: IMM_Z11=2'b00, IMM_Z19=2'b01, IMM_WIDE=2'b10, IMM_Z7=2'b11
  - state_t enum: S_IDLE, S_WIDE
  - iclass_t enum: R, I11, B19, S7, WIDE
  - opcode class constants
- One sub-module, imm_class_decode: combinational, opcode -> {iclass_t, imm_src_t}. It is reused later by the hazard unit.

Test Plan:
- Reset: hold rst=0 mid-S_WIDE, then release -> out_valid=0, Imm=0, state S_IDLE, first beat decoded fresh.
- I11: opcode=5'b01000, Instr[10:0]=11'h7FF, in_valid=1, out_ready=1 -> ImmSrc=00 that cycle; next cycle out_valid=1, Imm=24'h0007FF, OpOut=5'b01000.
- WIDE: beat1 opcode=5'b11100, Instr[11:0]=12'hABC; beat2 Instr[11:0]=12'h123 -> ImmSrc=10 both beats; no out_valid after beat1; after beat2 Imm=24'hABC123, OpOut=5'b11100.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, Imm stable. Raise out_ready with a B19 word (field 19'h7FFFF) -> Imm=24'h07FFFF next cycle, back-to-back.
- Flush in S_WIDE, asserted the same cycle as in_valid -> no accept, state S_IDLE. A following S7 word (Instr[6:0]=7'h55) yields Imm=24'h000055.
- Stall=1 with in_valid=1 for 2 cycles -> in_ready=0, no state change. With IMM_SEQ_PERF_EN, counters are unchanged until the instruction completes.

Source files
------------

// File: rtl/imm_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imm_seq_pkg
// Brief   : Shared types and opcode-class constants for the decode-stage
//           immediate sequencer and the opcode class decoder.
// Revision: 1.0  initial release
// ============================================================================
package imm_seq_pkg;

    // Selector sent to the zero-extend unit
    typedef enum logic [1:0] {
        IMM_Z11  = 2'b00,
        IMM_Z19  = 2'b01,
        IMM_WIDE = 2'b10,
        IMM_Z7   = 2'b11
    } imm_src_t;

    // Sequencer state: idle, or holding the high half of a wide immediate
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WIDE = 1'b1
    } state_t;

    // Instruction classes
    typedef enum logic [2:0] {
        R    = 3'd0,
        I11  = 3'd1,
        B19  = 3'd2,
        S7   = 3'd3,
        WIDE = 3'd4
    } iclass_t;

    // Class groups on the top two opcode bits (bit 2 is don't-care)
    localparam logic [1:0] c_grp_r   = 2'b00;
    localparam logic [1:0] c_grp_i11 = 2'b01;
    localparam logic [1:0] c_grp_b19 = 2'b10;

    // Classes on the top three opcode bits
    localparam logic [2:0] c_op_s7   = 3'b110;
    localparam logic [2:0] c_op_wide = 3'b111;

endpackage : imm_seq_pkg
`default_nettype wire

// File: rtl/imm_class_decode.sv
`default_nettype none
// ============================================================================
// Module  : imm_class_decode
// Brief   : Combinational opcode -> {instruction class, extend selector}.
//           Shared by the immediate sequencer and the hazard unit.
// Revision: 1.0  initial release
// ============================================================================
module imm_class_decode
    import imm_seq_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output iclass_t        iclass,
    output imm_src_t       imm_src
);

    logic [2:0] w_top3;
    logic       w_unused;

    assign w_top3   = opcode[OPW-1 -: 3];
    // Low opcode bits do not affect the class
    assign w_unused = ^opcode[OPW-4:0];

    // Classify on the top three opcode bits
    always_comb begin
        iclass  = R;
        imm_src = IMM_Z11;
        if (w_top3 == c_op_wide) begin
            iclass  = WIDE;
            imm_src = IMM_WIDE;
        end else if (w_top3 == c_op_s7) begin
            iclass  = S7;
            imm_src = IMM_Z7;
        end else begin
            case (w_top3[2:1])
                c_grp_i11: begin
                    iclass  = I11;
                    imm_src = IMM_Z11;
                end
                c_grp_b19: begin
                    iclass  = B19;
                    imm_src = IMM_Z19;
                end
                default: begin
                    iclass  = R;
                    imm_src = IMM_Z11;
                end
            endcase
        end
    end

endmodule : imm_class_decode
`default_nettype wire

// File: rtl/imm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imm_seq_ctrl
// Brief   : Decode-stage immediate sequencer. Classifies each fetched word,
//           steers the extend unit, registers the immediate and opcode toward
//           ID/EX, and assembles two-beat wide immediates.
//           Optional macro IMM_SEQ_PERF_EN adds saturating completion counters.
// Revision: 1.0  initial release
// ============================================================================
module imm_seq_ctrl
    import imm_seq_pkg::*;
#(
    parameter int N   = 24,
    parameter int OPW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   Instr,
    input  logic           stall,
    input  logic           flush,
    output logic [1:0]     ImmSrc,
    input  logic [N-1:0]   ExtImm,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   Imm,
    output logic [OPW-1:0] OpOut
`ifdef IMM_SEQ_PERF_EN
    ,
    output logic [15:0]    perf_instr_cnt,
    output logic [15:0]    perf_wide_cnt
`endif
);

    localparam int c_half = N / 2;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_half-1:0] r_hi;
    logic [c_half-1:0] w_hi_nxt;
    logic              r_out_valid;
    logic              w_out_valid_nxt;
    logic [N-1:0]      r_imm;
    logic [N-1:0]      w_imm_nxt;
    logic [OPW-1:0]    r_op;
    logic [OPW-1:0]    w_op_nxt;

    logic [OPW-1:0]    w_opcode;
    logic [c_half-1:0] w_lo;
    iclass_t           w_iclass;
    imm_src_t          w_dec_src;
    imm_src_t          w_src;
    logic              w_acc;
    logic              w_complete;
    logic              w_wide_done;
    logic              w_unused;

    assign w_opcode = Instr[N-1 -: OPW];
    assign w_lo     = Instr[c_half-1:0];
    // Middle field bits only reach the datapath through the extend unit
    assign w_unused = ^Instr[N-OPW-1:c_half];

    imm_class_decode #(
        .OPW     (OPW)
    ) u_decode (
        .opcode  (w_opcode),
        .iclass  (w_iclass),
        .imm_src (w_dec_src)
    );

    // An input beat may enter only when the output slot is free or draining
    assign in_ready = rst & ~stall & ~flush & (~r_out_valid | out_ready);
    assign w_acc    = in_valid & in_ready;

    // Extend selector: forced to WIDE while holding the high half
    always_comb begin
        w_src = IMM_Z11;
        if (rst) begin
            if (r_state == S_WIDE) begin
                w_src = IMM_WIDE;
            end else begin
                w_src = w_dec_src;
            end
        end
    end

    assign ImmSrc = w_src;

    // Next-state and output-register logic
    always_comb begin
        w_state_nxt     = r_state;
        w_hi_nxt        = r_hi;
        w_out_valid_nxt = r_out_valid;
        w_imm_nxt       = r_imm;
        w_op_nxt        = r_op;
        if (flush) begin
            // Kill any result and drop a half-built wide immediate
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = S_IDLE;
        end else begin
            if (r_out_valid && out_ready) begin
                w_out_valid_nxt = 1'b0;
            end
            if (w_acc) begin
                if (r_state == S_WIDE) begin
                    // Second beat: low half, opcode bits ignored
                    w_imm_nxt       = {r_hi, w_lo};
                    w_out_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if (w_iclass == WIDE) begin
                    // First beat: park the high half, nothing emitted yet
                    w_hi_nxt    = w_lo;
                    w_op_nxt    = w_opcode;
                    w_state_nxt = S_WIDE;
                end else begin
                    w_imm_nxt       = (w_iclass == R) ? '0 : ExtImm;
                    w_op_nxt        = w_opcode;
                    w_out_valid_nxt = 1'b1;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_hi        <= '0;
            r_out_valid <= 1'b0;
            r_imm       <= '0;
            r_op        <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_hi        <= w_hi_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_imm       <= w_imm_nxt;
            r_op        <= w_op_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign Imm       = r_imm;
    assign OpOut     = r_op;

    // A completion is any accepted beat that sets out_valid
    assign w_complete  = ~flush & w_acc & ((r_state == S_WIDE) | (w_iclass != WIDE));
    assign w_wide_done = ~flush & w_acc & (r_state == S_WIDE);

`ifdef IMM_SEQ_PERF_EN
    logic [15:0] r_perf_instr;
    logic [15:0] r_perf_wide;

    // Saturating completion counters; flush leaves them alone
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_instr <= '0;
            r_perf_wide  <= '0;
        end else begin
            if (w_complete && (r_perf_instr != 16'hFFFF)) begin
                r_perf_instr <= r_perf_instr + 16'd1;
            end
            if (w_wide_done && (r_perf_wide != 16'hFFFF)) begin
                r_perf_wide <= r_perf_wide + 16'd1;
            end
        end
    end

    assign perf_instr_cnt = r_perf_instr;
    assign perf_wide_cnt  = r_perf_wide;
`else
    logic w_unused_perf;
    assign w_unused_perf = w_complete ^ w_wide_done;
`endif

endmodule : imm_seq_ctrl
`default_nettype wire

// File: tb/tb_imm_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_imm_seq_ctrl
// Brief   : Directed self-checking bench for imm_seq_ctrl with a behavioural
//           zero-extend unit.
// Revision: 1.0  initial release
// ============================================================================
module tb_imm_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] Instr;
    logic        stall;
    logic        flush;
    logic [1:0]  ImmSrc;
    logic [23:0] ExtImm;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] Imm;
    logic [4:0]  OpOut;
`ifdef IMM_SEQ_PERF_EN
    logic [15:0] perf_instr_cnt;
    logic [15:0] perf_wide_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    imm_seq_ctrl #(
        .N   (24),
        .OPW (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Instr     (Instr),
        .stall     (stall),
        .flush     (flush),
        .ImmSrc    (ImmSrc),
        .ExtImm    (ExtImm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Imm       (Imm),
        .OpOut     (OpOut)
`ifdef IMM_SEQ_PERF_EN
        ,
        .perf_instr_cnt (perf_instr_cnt),
        .perf_wide_cnt  (perf_wide_cnt)
`endif
    );

    // Behavioural zero-extend unit; the WIDE selector yields junk on purpose
    always_comb begin
        ExtImm = 24'hDEADBE;
        case (ImmSrc)
            2'b00:   ExtImm = {13'b0, Instr[10:0]};
            2'b01:   ExtImm = {5'b0, Instr[18:0]};
            2'b11:   ExtImm = {17'b0, Instr[6:0]};
            default: ExtImm = 24'hDEADBE;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        Instr     = 24'hE00ABC;
        #2;
        check("rst_immsrc",   {30'b0, ImmSrc}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid",{31'b0, out_valid}, 32'd0);
        check("rst_imm",      {8'b0, Imm}, 32'd0);
        check("rst_opout",    {27'b0, OpOut}, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Wide first beat, then asynchronous reset in the middle of S_WIDE
        in_valid = 1'b1;
        Instr    = 24'hE00FFF;
        #1;
        check("w0_immsrc",   {30'b0, ImmSrc}, 32'd2);
        check("w0_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("w0_no_valid", {31'b0, out_valid}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check("arst_immsrc",    {30'b0, ImmSrc}, 32'd0);
        check("arst_opout",     {27'b0, OpOut}, 32'd0);
        tick();
        rst = 1'b1;

        // I11 decoded fresh after reset
        in_valid = 1'b1;
        Instr    = 24'h47FFFF;
        #1;
        check("i11_immsrc",   {30'b0, ImmSrc}, 32'd0);
        check("i11_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("i11_valid", {31'b0, out_valid}, 32'd1);
        check("i11_imm",   {8'b0, Imm}, 32'h0007FF);
        check("i11_op",    {27'b0, OpOut}, 32'h08);
        tick();
        check("i11_drain", {31'b0, out_valid}, 32'd0);

        // Two-beat wide immediate
        in_valid = 1'b1;
        Instr    = 24'hE00ABC;
        #1;
        check("wide_b1_immsrc", {30'b0, ImmSrc}, 32'd2);
        tick();
        Instr = 24'h000123;
        #1;
        check("wide_b1_no_valid", {31'b0, out_valid}, 32'd0);
        check("wide_b1_op",       {27'b0, OpOut}, 32'h1C);
        check("wide_b2_immsrc",   {30'b0, ImmSrc}, 32'd2);
        tick();
        out_ready = 1'b0;
        Instr     = 24'h87FFFF;
        check("wide_valid", {31'b0, out_valid}, 32'd1);
        check("wide_imm",   {8'b0, Imm}, 32'hABC123);
        check("wide_op",    {27'b0, OpOut}, 32'h1C);

        // Backpressure for three cycles with a B19 word waiting
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", {31'b0, in_ready}, 32'd0);
            tick();
            check("bp_imm",   {8'b0, Imm}, 32'hABC123);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("b19_in_ready", {31'b0, in_ready}, 32'd1);
        check("b19_immsrc",   {30'b0, ImmSrc}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("b19_imm",   {8'b0, Imm}, 32'h07FFFF);
        check("b19_op",    {27'b0, OpOut}, 32'h10);
        check("b19_valid", {31'b0, out_valid}, 32'd1);
        tick();
        check("b19_drain", {31'b0, out_valid}, 32'd0);

        // Flush while holding a wide high half
        in_valid = 1'b1;
        Instr    = 24'hE00456;
        tick();
        Instr = 24'h000999;
        flush = 1'b1;
        #1;
        check("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", {31'b0, out_valid}, 32'd0);
        Instr = 24'hC07FD5;
        #1;
        check("s7_immsrc", {30'b0, ImmSrc}, 32'd3);
        tick();
        stall = 1'b1;
        Instr = 24'h400123;
        check("s7_imm",   {8'b0, Imm}, 32'h000055);
        check("s7_op",    {27'b0, OpOut}, 32'h18);
        check("s7_valid", {31'b0, out_valid}, 32'd1);

        // Stall for two cycles; the pending S7 result still drains
        #1;
        check("stall_in_ready0", {31'b0, in_ready}, 32'd0);
        tick();
        check("stall_drain", {31'b0, out_valid}, 32'd0);
        check("stall_imm",   {8'b0, Imm}, 32'h000055);
        check("stall_in_ready1", {31'b0, in_ready}, 32'd0);
        tick();
        check("stall_hold", {31'b0, out_valid}, 32'd0);
`ifdef IMM_SEQ_PERF_EN
        check("perf_instr_stall", {16'b0, perf_instr_cnt}, 32'd4);
        check("perf_wide_stall",  {16'b0, perf_wide_cnt}, 32'd1);
`endif
        stall = 1'b0;
        #1;
        check("unstall_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        Instr = 24'h27FFFF;
        check("post_stall_imm",   {8'b0, Imm}, 32'h000123);
        check("post_stall_op",    {27'b0, OpOut}, 32'h08);
        check("post_stall_valid", {31'b0, out_valid}, 32'd1);

        // Back-to-back R-type: immediate forced to zero
        tick();
        in_valid = 1'b0;
        check("r_imm",   {8'b0, Imm}, 32'd0);
        check("r_op",    {27'b0, OpOut}, 32'h04);
        check("r_valid", {31'b0, out_valid}, 32'd1);
`ifdef IMM_SEQ_PERF_EN
        check("perf_instr_end", {16'b0, perf_instr_cnt}, 32'd6);
        check("perf_wide_end",  {16'b0, perf_wide_cnt}, 32'd1);
`endif
        tick();
        check("r_drain", {31'b0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_imm_seq_ctrl
`default_nettype wire
